exe_mem_skid: RTL and testbench

- Pipeline boundary between the EXE stage (ALU result and overflow flag) and the MEM stage.
- Registers the ALU result and control bits, folds ALU overflow into the precise-exception fields, and suppresses side effects of an overflowing instruction.
- Provides a 2-entry skid buffer with valid/ready handshake, so a MEM stall never combinationally back-pressures EXE.

---
 rtl/exe_mem_skid_pkg.sv | 32 +++
 rtl/exe_mem_skid_if.sv | 56 +++++
 rtl/exe_mem_skid_exc_merge.sv | 27 ++
 rtl/exe_mem_skid.sv | 124 ++++++++++++
 tb/tb_exe_mem_skid.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/exe_mem_skid_pkg.sv
// Shared types for the EXE/MEM pipeline boundary: exception codes, the registered
// entry layout and the skid-buffer state encoding.
package exe_mem_skid_pkg;

  localparam int unsigned DataW = 32;

  typedef enum logic [4:0] {
    ExcInt  = 5'h00,
    ExcAdEL = 5'h04,
    ExcAdES = 5'h05,
    ExcOv   = 5'h0C
  } exc_code_e;

  typedef struct packed {
    logic [DataW-1:0] alu_out;
    logic [DataW-1:0] pc;
    logic [DataW-1:0] store_data;
    logic [4:0]       dst;
    logic             reg_wr;
    logic             mem_rd;
    logic             mem_wr;
    logic             exc_valid;
    logic [4:0]       exc_code;
  } exe_mem_entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/exe_mem_skid_if.sv
// EXE->MEM handshake bundle. The slave side is the skid buffer; Fwd_* exist only
// when MEM_FWD_EN is defined.
interface exe_mem_skid_if #(
  parameter int unsigned DATA_W = 32
);
  logic              EXE_Valid;
  logic              EXE_Ready;
  logic [DATA_W-1:0] EXE_ALUOut;
  logic              EXE_Overflow;
  logic [DATA_W-1:0] EXE_PC;
  logic [4:0]        EXE_Dst;
  logic              EXE_RegWr;
  logic              EXE_MemRd;
  logic              EXE_MemWr;
  logic [DATA_W-1:0] EXE_StoreData;
  logic              EXE_ExcValid;
  logic [4:0]        EXE_ExcCode;
  logic              MEM_Flush;
  logic              MEM_Ready;
  logic              MEM_Valid;
  logic [DATA_W-1:0] MEM_ALUOut;
  logic [DATA_W-1:0] MEM_PC;
  logic [DATA_W-1:0] MEM_StoreData;
  logic [4:0]        MEM_Dst;
  logic              MEM_RegWr;
  logic              MEM_MemRd;
  logic              MEM_MemWr;
  logic              MEM_ExcValid;
  logic [4:0]        MEM_ExcCode;
`ifdef MEM_FWD_EN
  logic              Fwd_Valid;
  logic [4:0]        Fwd_Dst;
  logic [DATA_W-1:0] Fwd_Data;
`endif

  modport slave (
    input  EXE_Valid, EXE_ALUOut, EXE_Overflow, EXE_PC, EXE_Dst, EXE_RegWr, EXE_MemRd,
           EXE_MemWr, EXE_StoreData, EXE_ExcValid, EXE_ExcCode, MEM_Flush, MEM_Ready,
    output EXE_Ready, MEM_Valid, MEM_ALUOut, MEM_PC, MEM_StoreData, MEM_Dst, MEM_RegWr,
           MEM_MemRd, MEM_MemWr, MEM_ExcValid, MEM_ExcCode
`ifdef MEM_FWD_EN
    , output Fwd_Valid, Fwd_Dst, Fwd_Data
`endif
  );

  modport master (
    output EXE_Valid, EXE_ALUOut, EXE_Overflow, EXE_PC, EXE_Dst, EXE_RegWr, EXE_MemRd,
           EXE_MemWr, EXE_StoreData, EXE_ExcValid, EXE_ExcCode, MEM_Flush, MEM_Ready,
    input  EXE_Ready, MEM_Valid, MEM_ALUOut, MEM_PC, MEM_StoreData, MEM_Dst, MEM_RegWr,
           MEM_MemRd, MEM_MemWr, MEM_ExcValid, MEM_ExcCode
`ifdef MEM_FWD_EN
    , input Fwd_Valid, Fwd_Dst, Fwd_Data
`endif
  );

endinterface

// File: rtl/exe_mem_skid_exc_merge.sv
// Folds ALU overflow into the precise-exception fields and kills the side effects
// of any instruction that carries an exception.
module exe_mem_skid_exc_merge
  import exe_mem_skid_pkg::*;
#(
  parameter logic [4:0] EXC_OV = ExcOv
) (
  input  exe_mem_entry_t entry_i,
  input  logic           overflow_i,
  output exe_mem_entry_t entry_o
);

  always_comb begin
    entry_o = entry_i;
    // An older upstream exception keeps its code; overflow only matters otherwise.
    if (!entry_i.exc_valid && overflow_i) begin
      entry_o.exc_valid = 1'b1;
      entry_o.exc_code  = EXC_OV;
    end
    if (entry_o.exc_valid) begin
      entry_o.reg_wr = 1'b0;
      entry_o.mem_rd = 1'b0;
      entry_o.mem_wr = 1'b0;
    end
  end

endmodule

// File: rtl/exe_mem_skid.sv
// EXE/MEM pipeline register with a 2-entry skid buffer; EXE_Ready is purely
// registered so a MEM stall never reaches EXE combinationally. Optional: MEM_FWD_EN.
module exe_mem_skid
  import exe_mem_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter logic [4:0]  EXC_OV = ExcOv
) (
  input logic           clk,
  input logic           resetn,
  exe_mem_skid_if.slave bus
);

  if (DATA_W != DataW) begin : g_width_check
    $error("DATA_W must match exe_mem_skid_pkg::DataW");
  end

  state_e         state_q, state_d;
  exe_mem_entry_t main_q, skid_q, in_entry, merged, mem_out;
  logic           exe_ready, mem_valid, in_fire, out_fire;
  logic           load_main_in, load_main_skid, load_skid;

  assign exe_ready = (state_q != StFull);
  assign mem_valid = (state_q != StEmpty);
  assign in_fire   = bus.EXE_Valid & exe_ready;
  assign out_fire  = mem_valid & bus.MEM_Ready;

  always_comb begin
    in_entry            = '0;
    in_entry.alu_out    = bus.EXE_ALUOut;
    in_entry.pc         = bus.EXE_PC;
    in_entry.store_data = bus.EXE_StoreData;
    in_entry.dst        = bus.EXE_Dst;
    in_entry.reg_wr     = bus.EXE_RegWr;
    in_entry.mem_rd     = bus.EXE_MemRd;
    in_entry.mem_wr     = bus.EXE_MemWr;
    in_entry.exc_valid  = bus.EXE_ExcValid;
    in_entry.exc_code   = bus.EXE_ExcCode;
  end

  // Gate overflow with valid so a garbage flag on an idle cycle cannot leak in.
  exe_mem_skid_exc_merge #(
    .EXC_OV (EXC_OV)
  ) u_exc_merge (
    .entry_i    (in_entry),
    .overflow_i (bus.EXE_Valid & bus.EXE_Overflow),
    .entry_o    (merged)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.MEM_Flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (in_fire) state_d = StOne;
        StOne: begin
          if (out_fire && !in_fire) state_d = StEmpty;
          else if (in_fire && !out_fire) state_d = StFull;
        end
        StFull:  if (out_fire) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!bus.MEM_Flush) begin
      unique case (state_q)
        StEmpty: load_main_in = in_fire;
        StOne: begin
          load_main_in = in_fire & out_fire;
          load_skid    = in_fire & ~out_fire;
        end
        StFull:  load_main_skid = out_fire;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) main_q <= merged;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid) skid_q <= merged;
    end
  end

  // Stale data stays in main_q after drain/flush, so zero the fields when invalid.
  assign mem_out = mem_valid ? main_q : '0;

  assign bus.EXE_Ready     = exe_ready;
  assign bus.MEM_Valid     = mem_valid;
  assign bus.MEM_ALUOut    = mem_out.alu_out;
  assign bus.MEM_PC        = mem_out.pc;
  assign bus.MEM_StoreData = mem_out.store_data;
  assign bus.MEM_Dst       = mem_out.dst;
  assign bus.MEM_RegWr     = mem_out.reg_wr;
  assign bus.MEM_MemRd     = mem_out.mem_rd;
  assign bus.MEM_MemWr     = mem_out.mem_wr;
  assign bus.MEM_ExcValid  = mem_out.exc_valid;
  assign bus.MEM_ExcCode   = mem_out.exc_code;

`ifdef MEM_FWD_EN
  assign bus.Fwd_Valid = mem_valid & mem_out.reg_wr & ~mem_out.mem_rd & (mem_out.dst != 5'd0);
  assign bus.Fwd_Dst   = mem_out.dst;
  assign bus.Fwd_Data  = mem_out.alu_out;
`endif

endmodule

// File: tb/tb_exe_mem_skid.sv
// Directed bench for exe_mem_skid: a per-cycle vector table plus hand-written
// flush, mid-stream reset and (with MEM_FWD_EN) forwarding sequences.
module tb_exe_mem_skid;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exe_mem_skid_if #(.DATA_W(32)) bus ();

  exe_mem_skid #(
    .DATA_W (32),
    .EXC_OV (5'h0C)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic        ovf;
    logic        rw;
    logic        mw;
    logic        ev;
    logic [4:0]  ec;
    logic        fl;
    logic        mr;
    logic        e_rdy;
    logic        e_val;
    logic [31:0] e_alu;
    logic        e_rw;
    logic        e_mw;
    logic        e_ev;
    logic [4:0]  e_ec;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // PC, store data and Dst are derived from ALUOut so every field is traceable.
  task automatic drive(input vec_t t);
    bus.EXE_Valid     = t.v;
    bus.EXE_ALUOut    = t.alu;
    bus.EXE_Overflow  = t.ovf;
    bus.EXE_PC        = 32'h0040_0000 | t.alu;
    bus.EXE_StoreData = ~t.alu;
    bus.EXE_Dst       = t.alu[4:0];
    bus.EXE_RegWr     = t.rw;
    bus.EXE_MemRd     = 1'b0;
    bus.EXE_MemWr     = t.mw;
    bus.EXE_ExcValid  = t.ev;
    bus.EXE_ExcCode   = t.ec;
    bus.MEM_Flush     = t.fl;
    bus.MEM_Ready     = t.mr;
  endtask

  task automatic drive_simple(input logic v, input logic [31:0] alu, input logic fl,
                              input logic mr);
    vec_t t;
    t = '{v, alu, 1'b0, 1'b1, 1'b0, 1'b0, 5'h0, fl, mr,
          1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0};
    drive(t);
  endtask

  initial begin
    //        v     alu            ovf   rw    mw    ev    ec     fl    mr
    //        e_rdy e_val e_alu          e_rw  e_mw  e_ev  e_ec
    vecs[0]  = '{1'b1, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b1, 32'h1,        1'b1, 1'b0, 1'b0, 5'h0};
    vecs[1]  = '{1'b1, 32'h2,        1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b1, 32'h2,        1'b1, 1'b0, 1'b0, 5'h0};
    vecs[2]  = '{1'b1, 32'h3,        1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b1, 32'h3,        1'b1, 1'b0, 1'b0, 5'h0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'h0};
    vecs[4]  = '{1'b1, 32'h10,       1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b0,
                 1'b1, 1'b1, 32'h10,       1'b1, 1'b0, 1'b0, 5'h0};
    vecs[5]  = '{1'b1, 32'h20,       1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b0,
                 1'b0, 1'b1, 32'h10,       1'b1, 1'b0, 1'b0, 5'h0};
    vecs[6]  = '{1'b1, 32'h30,       1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b0,
                 1'b0, 1'b1, 32'h10,       1'b1, 1'b0, 1'b0, 5'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b1, 32'h20,       1'b1, 1'b0, 1'b0, 5'h0};
    vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'h0};
    vecs[9]  = '{1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 5'h0, 1'b0, 1'b0,
                 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 5'h0C};
    vecs[10] = '{1'b1, 32'h44,       1'b1, 1'b1, 1'b1, 1'b1, 5'h04, 1'b0, 1'b1,
                 1'b1, 1'b1, 32'h44,       1'b0, 1'b0, 1'b1, 5'h04};
    vecs[11] = '{1'b1, 32'h55,       1'b0, 1'b1, 1'b1, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b1, 32'h55,       1'b1, 1'b1, 1'b0, 5'h0};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'h0};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 5'h0,  1'b0, 1'b0,
                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'h0};
    vecs[14] = '{1'b1, 32'h66,       1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b0, 1'b0,
                 1'b1, 1'b1, 32'h66,       1'b1, 1'b0, 1'b0, 5'h0};
    vecs[15] = '{1'b1, 32'h77,       1'b0, 1'b1, 1'b0, 1'b0, 5'h0,  1'b1, 1'b0,
                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'h0};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'h0,  1'b0, 1'b1,
                 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 5'h0};

    // Reset state
    drive_simple(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.MEM_Valid), 32'h0);
    chk("rst_alu", bus.MEM_ALUOut, 32'h0);
    chk("rst_exccode", 32'(bus.MEM_ExcCode), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.EXE_Ready), 32'h1);

    for (int i = 0; i < NVec; i++) begin
      vec_t t;
      logic [31:0] e_pc, e_sd, e_dst;
      t = vecs[i];
      @(negedge clk);
      drive(t);
      @(posedge clk);
      #1;
      e_pc  = t.e_val ? (32'h0040_0000 | t.e_alu) : 32'h0;
      e_sd  = t.e_val ? ~t.e_alu : 32'h0;
      e_dst = t.e_val ? {27'h0, t.e_alu[4:0]} : 32'h0;
      chk($sformatf("v%0d_ready", i), 32'(bus.EXE_Ready), 32'(t.e_rdy));
      chk($sformatf("v%0d_valid", i), 32'(bus.MEM_Valid), 32'(t.e_val));
      chk($sformatf("v%0d_alu", i), bus.MEM_ALUOut, t.e_alu);
      chk($sformatf("v%0d_regwr", i), 32'(bus.MEM_RegWr), 32'(t.e_rw));
      chk($sformatf("v%0d_memwr", i), 32'(bus.MEM_MemWr), 32'(t.e_mw));
      chk($sformatf("v%0d_excvalid", i), 32'(bus.MEM_ExcValid), 32'(t.e_ev));
      chk($sformatf("v%0d_exccode", i), 32'(bus.MEM_ExcCode), 32'(t.e_ec));
      chk($sformatf("v%0d_pc", i), bus.MEM_PC, e_pc);
      chk($sformatf("v%0d_store", i), bus.MEM_StoreData, e_sd);
      chk($sformatf("v%0d_dst", i), 32'(bus.MEM_Dst), e_dst);
    end

    // Flush from FULL with a simultaneous incoming instruction
    @(negedge clk); drive_simple(1'b1, 32'hA1, 1'b0, 1'b0);
    @(negedge clk); drive_simple(1'b1, 32'hA2, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("full_ready", 32'(bus.EXE_Ready), 32'h0);
    chk("full_alu", bus.MEM_ALUOut, 32'hA1);
    @(negedge clk); drive_simple(1'b1, 32'hA3, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("flush_valid", 32'(bus.MEM_Valid), 32'h0);
    chk("flush_ready", 32'(bus.EXE_Ready), 32'h1);
    @(negedge clk); drive_simple(1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("flush_dropped_valid", 32'(bus.MEM_Valid), 32'h0);
    chk("flush_dropped_alu", bus.MEM_ALUOut, 32'h0);

    // Asynchronous reset while FULL
    @(negedge clk); drive_simple(1'b1, 32'hB1, 1'b0, 1'b0);
    @(negedge clk); drive_simple(1'b1, 32'hB2, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_ready", 32'(bus.EXE_Ready), 32'h0);
    @(negedge clk);
    drive_simple(1'b0, 32'h0, 1'b0, 1'b0);
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.MEM_Valid), 32'h0);
    chk("async_rst_alu", bus.MEM_ALUOut, 32'h0);
    chk("async_rst_pc", bus.MEM_PC, 32'h0);
    chk("async_rst_regwr", 32'(bus.MEM_RegWr), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.EXE_Ready), 32'h1);
    chk("post_rst_valid", 32'(bus.MEM_Valid), 32'h0);

`ifdef MEM_FWD_EN
    @(negedge clk);
    drive_simple(1'b1, 32'h1234, 1'b0, 1'b1);
    bus.EXE_Dst = 5'd0;
    @(posedge clk); #1;
    chk("fwd_dst0_valid", 32'(bus.Fwd_Valid), 32'h0);
    @(negedge clk);
    drive_simple(1'b1, 32'hABCD, 1'b0, 1'b1);
    bus.EXE_Dst = 5'd5;
    @(posedge clk); #1;
    chk("fwd_valid", 32'(bus.Fwd_Valid), 32'h1);
    chk("fwd_data", bus.Fwd_Data, 32'hABCD);
    chk("fwd_dst", 32'(bus.Fwd_Dst), 32'h5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
